digit_serial_adder: RTL and testbench

//   Sequential front end for the 2-bit ripple carry adder (adder_2bit). Accepts WIDTH-bit

---
 rtl/digit_serial_adder.sv | 130 +++++++++++++
 tb/tb_digit_serial_adder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/digit_serial_adder.sv
// Digit-serial adder: a WIDTH-bit add performed 2 bits per clock on one shared
// 2-bit ripple-carry slice, with the slice carry held in a register between cycles.

module adder_2bit (
    input  logic [1:0] A,
    input  logic [1:0] B,
    input  logic       Cin,
    output logic [1:0] S,
    output logic       Cout
);
    logic c1_s;

    assign S[0] = A[0] ^ B[0] ^ Cin;
    assign c1_s = (A[0] & B[0]) | (Cin & (A[0] ^ B[0]));
    assign S[1] = A[1] ^ B[1] ^ c1_s;
    assign Cout = (A[1] & B[1]) | (c1_s & (A[1] ^ B[1]));
endmodule

module digit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             overflow
);
    localparam int N  = WIDTH / 2;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] LAST_K = KW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] s_q;
    logic             carry_q;
    logic             cout_q;
    logic             ovf_q;
    logic [KW-1:0]    k_q;
    logic [KW-1:0]    k_d;

    logic [1:0]       a_sl_s;
    logic [1:0]       b_sl_s;
    logic [1:0]       sum_s;
    logic             c_s;
    logic             last_s;

    assign a_sl_s = a_q[{k_q, 1'b0} +: 2];
    assign b_sl_s = b_q[{k_q, 1'b0} +: 2];
    assign k_d    = k_q + 1'b1;
    assign last_s = (k_q == LAST_K);

    adder_2bit u_slice (
        .A    (a_sl_s),
        .B    (b_sl_s),
        .Cin  (carry_q),
        .S    (sum_s),
        .Cout (c_s)
    );

    // Control FSM and datapath registers; the carry between slices lives only in carry_q
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            k_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= A;
                        b_q     <= B;
                        carry_q <= Cin;
                        k_q     <= '0;
                        s_q     <= '0;
                        cout_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    s_q[{k_q, 1'b0} +: 2] <= sum_s;
                    carry_q <= c_s;
                    k_q     <= k_d;
                    if (last_s) begin
                        // sum_s[1] is the final sum MSB, so overflow needs no wait for s_q
                        cout_q  <= c_s;
                        ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) & (sum_s[1] != a_q[WIDTH-1]);
                        state_q <= DONE;
                    end else begin
                        state_q <= RUN;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready    = (state_q == IDLE);
    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign S        = s_q;
    assign Cout     = cout_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed and randomised checks of digit_serial_adder at WIDTH=8, 2 and 16.

module tb_digit_serial_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic       start8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = 8'h00, b8 = 8'h00, s8;
    logic       rdy8, busy8, done8, cout8, ovf8;

    // WIDTH=2 instance
    logic       start2 = 1'b0, cin2 = 1'b0;
    logic [1:0] a2 = 2'd0, b2 = 2'd0, s2;
    logic       rdy2, busy2, done2, cout2, ovf2;

    // WIDTH=16 instance
    logic        start16 = 1'b0, cin16 = 1'b0;
    logic [15:0] a16 = 16'h0, b16 = 16'h0, s16;
    logic        rdy16, busy16, done16, cout16, ovf16;

    digit_serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .Cin(cin8),
        .ready(rdy8), .busy(busy8), .done(done8), .S(s8), .Cout(cout8), .overflow(ovf8)
    );

    digit_serial_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .A(a2), .B(b2), .Cin(cin2),
        .ready(rdy2), .busy(busy2), .done(done2), .S(s2), .Cout(cout2), .overflow(ovf2)
    );

    digit_serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .A(a16), .B(b16), .Cin(cin16),
        .ready(rdy16), .busy(busy16), .done(done16), .S(s16), .Cout(cout16), .overflow(ovf16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Run one 8-bit op from IDLE; checks busy, latency, result and the one-cycle done pulse
    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [7:0] es, input logic ec, input logic eo);
        int n;
        @(negedge clk);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        n = 1;
        check({tag, " busy"}, {31'd0, busy8}, 32'd1);
        while (!done8 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, n, 32'd5);
        check({tag, " S"}, {24'd0, s8}, {24'd0, es});
        check({tag, " Cout"}, {31'd0, cout8}, {31'd0, ec});
        check({tag, " ovf"}, {31'd0, ovf8}, {31'd0, eo});
        @(negedge clk);
        check({tag, " done width"}, {31'd0, done8}, 32'd0);
        check({tag, " ready"}, {31'd0, rdy8}, 32'd1);
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic c,
                        input logic [15:0] es, input logic ec, input logic eo);
        int n;
        @(negedge clk);
        a16 = a; b16 = b; cin16 = c; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        n = 1;
        while (!done16 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("w16 latency", n, 32'd9);
        check("w16 sum", {15'd0, cout16, s16}, {15'd0, ec, es});
        check("w16 ovf", {31'd0, ovf16}, {31'd0, eo});
    endtask

    initial begin
        logic [7:0]  ra8, rb8;
        logic [8:0]  rs8;
        logic [15:0] ra16, rb16;
        logic [16:0] rs16;
        logic        rc;
        int          n;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset ready", {31'd0, rdy8}, 32'd1);
        check("reset busy", {31'd0, busy8}, 32'd0);
        check("reset done", {31'd0, done8}, 32'd0);
        check("reset result", {22'd0, ovf8, cout8, s8}, 32'd0);

        op8("t1", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
        op8("t2", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        op8("t3a", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        op8("t3b", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);

        // start pulsed during RUN must be ignored
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        n = 2;
        while (!done8 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t4 latency", n, 32'd5);
        check("t4 S", {24'd0, s8}, 32'h02);
        check("t4 Cout", {31'd0, cout8}, 32'd0);
        @(negedge clk);
        check("t4 no requeue", {31'd0, busy8}, 32'd0);

        // reset during the second RUN cycle
        @(negedge clk);
        a8 = 8'h55; b8 = 8'hAA; cin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5 S", {24'd0, s8}, 32'd0);
        check("t5 Cout", {31'd0, cout8}, 32'd0);
        check("t5 done", {31'd0, done8}, 32'd0);
        check("t5 ready", {31'd0, rdy8}, 32'd1);
        op8("t5b", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);

        // WIDTH=2
        @(negedge clk);
        a2 = 2'd3; b2 = 2'd3; cin2 = 1'b1; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        n = 1;
        while (!done2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("w2 latency", n, 32'd2);
        check("w2 S", {30'd0, s2}, 32'd3);
        check("w2 Cout", {31'd0, cout2}, 32'd1);
        check("w2 ovf", {31'd0, ovf2}, 32'd0);

        for (int i = 0; i < 1000; i++) begin
            ra8 = 8'($urandom);
            rb8 = 8'($urandom);
            rc  = 1'($urandom);
            rs8 = {1'b0, ra8} + {1'b0, rb8} + {8'd0, rc};
            op8("rnd8", ra8, rb8, rc, rs8[7:0], rs8[8],
                (ra8[7] == rb8[7]) && (rs8[7] != ra8[7]));
        end

        for (int i = 0; i < 1000; i++) begin
            ra16 = 16'($urandom);
            rb16 = 16'($urandom);
            rc   = 1'($urandom);
            rs16 = {1'b0, ra16} + {1'b0, rb16} + {16'd0, rc};
            op16(ra16, rb16, rc, rs16[15:0], rs16[16],
                 (ra16[15] == rb16[15]) && (rs16[15] != ra16[15]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
